// File: rtl/noc_ni_tx_if.sv
// noc_ni_tx_if: core-side request/payload handshakes and the router
// local-port flit/credit link of the NoC network-interface transmitter.
interface noc_ni_tx_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_dest;
    logic [7:0]  req_len;
    logic        data_valid;
    logic        data_ready;
    logic [27:0] data_in;
    logic [31:0] flit_out;
    logic        flit_write;
    logic        credit_in;

    modport master (
        output req_valid, req_dest, req_len,
        output data_valid, data_in, credit_in,
        input  req_ready, data_ready, flit_out, flit_write
    );

    modport slave (
        input  req_valid, req_dest, req_len,
        input  data_valid, data_in, credit_in,
        output req_ready, data_ready, flit_out, flit_write
    );
endinterface

// File: rtl/noc_ni_tx.sv
// noc_ni_tx: packs requests + payload words into flits for the router local
// port under credit flow control. NI_TX_SEQNUM_EN adds a header sequence number.
module noc_ni_tx #(
    parameter logic [3:0] LOCAL_ID = 4'd0,
    parameter int unsigned CREDITS = 4,
    parameter logic [7:0] MAX_LEN  = 8'd64
) (
    input  logic       clk,
    input  logic       rst,
    noc_ni_tx_if.slave ni,
    output logic       busy,
    output logic       pkt_done,
    output logic       credit_err
);
    localparam logic [3:0] CMAX = 4'(CREDITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  dest_q, credits;
    logic [7:0]  len_q, rem_q, seq, len_in;
    logic        rdy_q, data_rdy, req_acc, data_acc, has_cred;
    logic        issue, last, write_q, done_q;
    logic [31:0] flit_d, flit_q;

    assign has_cred = (credits != 4'd0);
    assign len_in   = (ni.req_len > MAX_LEN) ? MAX_LEN : ni.req_len;
    assign req_acc  = (state == IDLE) && rdy_q && ni.req_valid;
    assign data_rdy = (state == BODY) && has_cred;
    assign data_acc = ni.data_valid && data_rdy;

    assign ni.req_ready  = rdy_q;
    assign ni.data_ready = data_rdy;
    assign ni.flit_out   = flit_q;
    assign ni.flit_write = write_q;
    assign pkt_done      = done_q;
    assign busy          = (state != IDLE);

`ifdef NI_TX_SEQNUM_EN
    // Packet sequence number, advanced with each packet's last flit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) seq <= 8'h00;
        else if (last) seq <= seq + 8'd1;
    end
`else
    assign seq = 8'h00;
`endif

    // Next state and flit to issue; header goes out on the accept edge
    // when a credit is available, otherwise HEAD waits for one
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        last      = 1'b0;
        flit_d    = flit_q;
        unique case (state)
            IDLE: begin
                if (req_acc) begin
                    if (has_cred) begin
                        issue     = 1'b1;
                        flit_d    = {8'h00, seq, len_in, LOCAL_ID, ni.req_dest};
                        last      = (len_in == 8'd0);
                        state_nxt = last ? IDLE : BODY;
                    end else begin
                        state_nxt = HEAD;
                    end
                end
            end
            HEAD: begin
                if (has_cred) begin
                    issue     = 1'b1;
                    flit_d    = {8'h00, seq, len_q, LOCAL_ID, dest_q};
                    last      = (len_q == 8'd0);
                    state_nxt = last ? IDLE : BODY;
                end
            end
            BODY: begin
                if (data_acc) begin
                    issue     = 1'b1;
                    flit_d    = {ni.data_in, dest_q};
                    last      = (rem_q == 8'd1);
                    state_nxt = last ? IDLE : BODY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, packet context and registered flit outputs; req_ready is
    // registered so there is always one idle cycle between packets
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rdy_q   <= 1'b0;
            dest_q  <= 4'd0;
            len_q   <= 8'd0;
            rem_q   <= 8'd0;
            flit_q  <= 32'd0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            rdy_q   <= (state == IDLE) && !req_acc;
            write_q <= issue;
            done_q  <= last;
            if (issue) flit_q <= flit_d;
            if (req_acc) begin
                dest_q <= ni.req_dest;
                len_q  <= len_in;
                rem_q  <= len_in;
            end else if (data_acc) begin
                rem_q <= rem_q - 8'd1;
            end
        end
    end

    // Credit counter: flit issue spends one, credit_in returns one;
    // a return at full count is flagged and dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits    <= CMAX;
            credit_err <= 1'b0;
        end else if (issue && !ni.credit_in) begin
            credits <= credits - 4'd1;
        end else if (!issue && ni.credit_in) begin
            if (credits == CMAX) credit_err <= 1'b1;
            else credits <= credits + 4'd1;
        end
    end
endmodule

// File: tb/tb_noc_ni_tx.sv
// tb_noc_ni_tx: directed vectors for noc_ni_tx (LOCAL_ID=5, CREDITS=4,
// MAX_LEN=64) plus hand sequences for credit stall, credit_err and reset.
module tb_noc_ni_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, pkt_done, credit_err;
    logic auto_cred = 1'b0;
    logic cin_manual = 1'b0;

    noc_ni_tx_if ifc ();

    assign ifc.credit_in = auto_cred ? ifc.flit_write : cin_manual;

    noc_ni_tx #(
        .LOCAL_ID (4'h5),
        .CREDITS  (4),
        .MAX_LEN  (8'd64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ni         (ifc),
        .busy       (busy),
        .pkt_done   (pkt_done),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  dest;
        logic [7:0]  len;
        logic [31:0] hdr;
        int          n;
        logic [27:0] base;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [31:0] fq[$];
    logic        dq[$];
    int          tq[$];
`ifdef NI_TX_SEQNUM_EN
    logic [7:0] seq_exp = 8'h00;
`endif

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (ifc.flit_write) begin
            fq.push_back(ifc.flit_out);
            dq.push_back(pkt_done);
            tq.push_back(cyc);
        end
        if (pkt_done) done_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_q();
        fq.delete();
        dq.delete();
        tq.delete();
    endtask

    task automatic wait_ready(input string nm);
        int k = 0;
        @(negedge clk);
        while (!ifc.req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(ifc.req_ready), 32'd1);
    endtask

    task automatic pulse();
        @(negedge clk);
        cin_manual = 1'b1;
        @(negedge clk);
        cin_manual = 1'b0;
    endtask

    task automatic send(input vec_t v);
        int k;
        int idx;
        int d0;
        int ones;
        logic acc;
        logic [31:0] h;
        h = v.hdr;
`ifdef NI_TX_SEQNUM_EN
        h[23:16] = seq_exp;
`endif
        clear_q();
        d0 = done_cnt;
        wait_ready("req_ready");
        ifc.req_valid = 1'b1;
        ifc.req_dest  = v.dest;
        ifc.req_len   = v.len;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        ifc.req_dest  = ~v.dest;
        ifc.req_len   = 8'hFF;
        idx = 0;
        k = 0;
        while (idx < v.n && k < 1000) begin
            ifc.data_valid = 1'b1;
            ifc.data_in    = v.base + 28'(idx);
            acc = ifc.data_ready;
            @(negedge clk);
            if (acc) idx++;
            k++;
        end
        ifc.data_valid = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("pkt_done_seen", 32'(done_cnt - d0), 32'd1);
        chk("flit_count", 32'(fq.size()), 32'(v.n + 1));
        if (fq.size() == v.n + 1) begin
            chk("header", fq[0], h);
            for (int i = 1; i <= v.n; i++)
                chk("payload", fq[i], {v.base + 28'(i - 1), v.dest});
            ones = 0;
            foreach (dq[i]) ones += int'(dq[i]);
            chk("done_once", 32'(ones), 32'd1);
            chk("done_last", 32'(dq[v.n]), 32'd1);
            chk("consecutive", 32'(tq[v.n] - tq[0]), 32'(v.n));
        end
`ifdef NI_TX_SEQNUM_EN
        seq_exp = seq_exp + 8'd1;
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[7];
        int d0;
        vt[0] = '{4'hA, 8'd2,   32'h0000025A, 2,  28'h1234567};
        vt[1] = '{4'h3, 8'd0,   32'h00000053, 0,  28'h0000000};
        vt[2] = '{4'h5, 8'd1,   32'h00000155, 1,  28'hFFFFFFF};
        vt[3] = '{4'hF, 8'd3,   32'h0000035F, 3,  28'h0ABCDEF};
        vt[4] = '{4'h0, 8'd200, 32'h00004050, 64, 28'h0000100};
        vt[5] = '{4'h1, 8'd65,  32'h00004051, 64, 28'h8000000};
        vt[6] = '{4'h2, 8'd64,  32'h00004052, 64, 28'h5555555};

        ifc.req_valid  = 1'b0;
        ifc.req_dest   = 4'h0;
        ifc.req_len    = 8'h00;
        ifc.data_valid = 1'b0;
        ifc.data_in    = 28'h0;

        // reset values
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_flit_out", ifc.flit_out, 32'h0);
        chk("rst_flit_write", 32'(ifc.flit_write), 32'd0);
        chk("rst_req_ready", 32'(ifc.req_ready), 32'd0);
        chk("rst_data_ready", 32'(ifc.data_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pkt_done", 32'(pkt_done), 32'd0);
        chk("rst_credit_err", 32'(credit_err), 32'd0);
        chk("rst_credits", 32'(dut.credits), 32'd4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", 32'(ifc.req_ready), 32'd1);

        // header-only packet and req_ready recovery
        auto_cred = 1'b1;
        wait_ready("t3_ready");
        ifc.req_valid = 1'b1;
        ifc.req_dest  = 4'h3;
        ifc.req_len   = 8'd0;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        chk("t3_flit", ifc.flit_out, 32'h00000053);
        chk("t3_write", 32'(ifc.flit_write), 32'd1);
        chk("t3_done", 32'(pkt_done), 32'd1);
        chk("t3_ready_low", 32'(ifc.req_ready), 32'd0);
        @(negedge clk);
        chk("t3_ready_back", 32'(ifc.req_ready), 32'd1);
        chk("t3_write_end", 32'(ifc.flit_write), 32'd0);

        // credit exhaustion stall and resume
        auto_cred = 1'b0;
        repeat (3) @(negedge clk);
        clear_q();
        d0 = done_cnt;
        wait_ready("t2_ready");
        ifc.req_valid  = 1'b1;
        ifc.req_dest   = 4'h7;
        ifc.req_len    = 8'd6;
        ifc.data_valid = 1'b1;
        ifc.data_in    = 28'h0000111;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("t2_stall_flits", 32'(fq.size()), 32'd4);
        chk("t2_data_ready", 32'(ifc.data_ready), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_write_idle", 32'(ifc.flit_write), 32'd0);
        repeat (2) pulse();
        repeat (4) @(negedge clk);
        chk("t2_two_more", 32'(fq.size()), 32'd6);
        chk("t2_not_done", 32'(done_cnt - d0), 32'd0);
        pulse();
        repeat (4) @(negedge clk);
        chk("t2_all", 32'(fq.size()), 32'd7);
        chk("t2_done", 32'(done_cnt - d0), 32'd1);
        if (dq.size() == 7) chk("t2_done_last", 32'(dq[6]), 32'd1);
        ifc.data_valid = 1'b0;

        // simultaneous issue + credit, then overflow credit
        repeat (2) pulse();
        chk("t5_cred2", 32'(dut.credits), 32'd2);
        wait_ready("t5_ready");
        ifc.req_valid  = 1'b1;
        ifc.req_dest   = 4'h1;
        ifc.req_len    = 8'd1;
        ifc.data_valid = 1'b1;
        ifc.data_in    = 28'h00000AA;
        cin_manual     = 1'b1;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        cin_manual    = 1'b0;
        chk("t5_same_cycle", 32'(dut.credits), 32'd2);
        chk("t5_hdr_write", 32'(ifc.flit_write), 32'd1);
        @(negedge clk);
        ifc.data_valid = 1'b0;
        chk("t5_cred1", 32'(dut.credits), 32'd1);
        chk("t5_done", 32'(pkt_done), 32'd1);
        repeat (3) pulse();
        chk("t5_full", 32'(dut.credits), 32'd4);
        chk("t5_no_err", 32'(credit_err), 32'd0);
        pulse();
        chk("t5_err", 32'(credit_err), 32'd1);
        chk("t5_no_wrap", 32'(dut.credits), 32'd4);
        repeat (5) @(negedge clk);
        chk("t5_err_sticky", 32'(credit_err), 32'd1);

        // reset in the middle of a packet body
        wait_ready("t6_ready");
        ifc.req_valid  = 1'b1;
        ifc.req_dest   = 4'h9;
        ifc.req_len    = 8'd5;
        ifc.data_valid = 1'b1;
        ifc.data_in    = 28'h0000123;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6_busy_rst", 32'(busy), 32'd0);
        chk("t6_write_rst", 32'(ifc.flit_write), 32'd0);
        chk("t6_flit_rst", ifc.flit_out, 32'h0);
        chk("t6_ready_rst", 32'(ifc.req_ready), 32'd0);
        chk("t6_dready_rst", 32'(ifc.data_ready), 32'd0);
        chk("t6_done_rst", 32'(pkt_done), 32'd0);
        chk("t6_err_rst", 32'(credit_err), 32'd0);
        @(negedge clk);
        ifc.data_valid = 1'b0;
        rst = 1'b1;
        chk("t6_cred_rst", 32'(dut.credits), 32'd4);
        clear_q();

        // table-driven packets with the router returning credits
        auto_cred = 1'b1;
        for (int i = 0; i < 7; i++) send(vt[i]);

`ifdef NI_TX_SEQNUM_EN
        // sequence counter wraps after 256 packets
        for (int i = 0; i < 257; i++) send(vt[1]);
        chk("seq_wrapped", 32'(seq_exp), 32'(8'd8));
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
